// File: rtl/memory_port_sequencer.sv
// rtl/memory_port_sequencer.sv - shares the combined A/D/A* memory between the CPU and a debug/loader port
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   cpu_dst, cpu_x              CPU store flags and result bus (passed through when not stalled)
//   cpu_stall                   CPU holds instruction and PC while high
//   mem_dst, mem_x              store flags and data bus to the combined memory
//   mem_a, mem_a_star           current A and RAM[A] from the combined memory
//   dbg_valid, dbg_ready        debug request handshake
//   dbg_we, dbg_addr, dbg_wdata debug request: direction, address, write data
//   dbg_done                    one-cycle completion pulse
//   dbg_rdata                   read result, held until the next read completes

package memory_port_sequencer_pkg;
    typedef struct packed {
        logic a;
        logic d;
        logic a_star;
    } dst_flag_t;
endpackage

module memory_port_sequencer
    import memory_port_sequencer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  dst_flag_t        cpu_dst,
    input  logic [WIDTH-1:0] cpu_x,
    output logic             cpu_stall,
    output dst_flag_t        mem_dst,
    output logic [WIDTH-1:0] mem_x,
    input  logic [WIDTH-1:0] mem_a,
    input  logic [WIDTH-1:0] mem_a_star,
    input  logic             dbg_valid,
    output logic             dbg_ready,
    input  logic             dbg_we,
    input  logic [WIDTH-1:0] dbg_addr,
    input  logic [WIDTH-1:0] dbg_wdata,
    output logic             dbg_done,
    output logic [WIDTH-1:0] dbg_rdata
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SET_ADDR = 3'd1,
        ACCESS   = 3'd2,
        RESTORE  = 3'd3,
        CPU_SLOT = 3'd4
    } state_t;

    state_t           state;
    logic             cap_we;
    logic [WIDTH-1:0] cap_addr;
    logic [WIDTH-1:0] cap_wdata;
    logic [WIDTH-1:0] saved_a;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Any in-flight request is dropped; A is left as last written.
            state     <= IDLE;
            dbg_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dbg_valid) begin
                        cap_we    <= dbg_we;
                        cap_addr  <= dbg_addr;
                        cap_wdata <= dbg_wdata;
                        state     <= SET_ADDR;
                    end
                end
                SET_ADDR: begin
                    // A already includes any CPU store from the accept cycle.
                    saved_a <= mem_a;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (!cap_we) begin
                        dbg_rdata <= mem_a_star;
                    end
                    state <= RESTORE;
                end
                RESTORE:  state <= CPU_SLOT;
                CPU_SLOT: state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    // Outputs decode from state; IDLE and CPU_SLOT pass the CPU straight through.
    always_comb begin
        mem_dst   = '0;
        mem_x     = '0;
        cpu_stall = 1'b0;
        dbg_ready = 1'b0;
        dbg_done  = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    mem_dst   = cpu_dst;
                    mem_x     = cpu_x;
                    dbg_ready = 1'b1;
                end
                SET_ADDR: begin
                    mem_dst.a = 1'b1;
                    mem_x     = cap_addr;
                    cpu_stall = 1'b1;
                end
                ACCESS: begin
                    cpu_stall = 1'b1;
                    if (cap_we) begin
                        mem_dst.a_star = 1'b1;
                        mem_x          = cap_wdata;
                    end
                end
                RESTORE: begin
                    mem_dst.a = 1'b1;
                    mem_x     = saved_a;
                    cpu_stall = 1'b1;
                    dbg_done  = 1'b1;
                end
                CPU_SLOT: begin
                    mem_dst = cpu_dst;
                    mem_x   = cpu_x;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_port_sequencer.sv
// tb/tb_memory_port_sequencer.sv - randomized scoreboard bench for memory_port_sequencer
module tb_memory_port_sequencer;
    import memory_port_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    dst_flag_t   cpu_dst = '0;
    logic [15:0] cpu_x = '0;
    logic        cpu_stall;
    dst_flag_t   mem_dst;
    logic [15:0] mem_x;
    logic [15:0] mem_a;
    logic [15:0] mem_a_star;
    logic        dbg_valid = 1'b0;
    logic        dbg_ready;
    logic        dbg_we = 1'b0;
    logic [15:0] dbg_addr = '0;
    logic [15:0] dbg_wdata = '0;
    logic        dbg_done;
    logic [15:0] dbg_rdata;

    memory_port_sequencer #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_dst(cpu_dst), .cpu_x(cpu_x), .cpu_stall(cpu_stall),
        .mem_dst(mem_dst), .mem_x(mem_x), .mem_a(mem_a), .mem_a_star(mem_a_star),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_done(dbg_done), .dbg_rdata(dbg_rdata)
    );

    always #5 clk = ~clk;

    // Combined memory the DUT drives.
    logic [15:0] a_reg;
    logic [15:0] d_reg;
    logic [15:0] ram [0:65535];
    assign mem_a      = a_reg;
    assign mem_a_star = ram[a_reg];
    always @(posedge clk) begin
        if (mem_dst.a_star) ram[a_reg] <= mem_x;
        if (mem_dst.a)      a_reg <= mem_x;
        if (mem_dst.d)      d_reg <= mem_x;
    end

    // Architectural reference: what A, D and RAM should hold as seen by the CPU.
    logic [15:0] m_a;
    logic [15:0] m_d;
    logic [15:0] m_ram [0:65535];
    int          ph;        // cycles since accept; 0 = free to accept
    logic        t_we;
    logic [15:0] t_addr;
    logic [15:0] t_wdata;

    typedef struct {
        int          cyc;
        logic        is_read;
        logic [15:0] rdata;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } req_t;
    req_t reqq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [15:0] held_rdata = '0;

    always @(posedge clk) cyc = cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: pops the scoreboard whenever the DUT signals completion.
    always @(negedge clk) begin
        if (!rst_n) begin
            held_rdata = '0;
        end else begin
            if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                chk("done_missing", 32'(sbq[0].cyc), 32'(cyc));
                void'(sbq.pop_front());
            end
            if (dbg_done) begin
                if (sbq.size() == 0) begin
                    chk("done_unexpected", 32'(dbg_done), 32'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    if (e.is_read) held_rdata = e.rdata;
                end
            end
            chk("rdata", 32'(dbg_rdata), 32'(held_rdata));
        end
    end

    // One clock of stimulus: drive, check against the model, advance the model.
    // The request at the head of reqq is offered; it is popped when accepted.
    task automatic run_cycle(input logic r, input dst_flag_t cd, input logic [15:0] cx);
        logic pass;
        logic [15:0] old_a;
        @(posedge clk);
        #2;
        rst_n   = r;
        cpu_dst = cd;
        cpu_x   = cx;
        dbg_valid = (reqq.size() > 0);
        if (reqq.size() > 0) begin
            dbg_we    = reqq[0].we;
            dbg_addr  = reqq[0].addr;
            dbg_wdata = reqq[0].wdata;
        end
        #1;
        if (!r) begin
            chk("rst_ready", 32'(dbg_ready), 32'd0);
            chk("rst_done", 32'(dbg_done), 32'd0);
            chk("rst_stall", 32'(cpu_stall), 32'd0);
            chk("rst_mem_dst", 32'(mem_dst), 32'd0);
            chk("rst_mem_x", 32'(mem_x), 32'd0);
            // An aborted transaction leaves A at the debug address once it was loaded.
            if (ph == 2 || ph == 3) m_a = t_addr;
            ph = 0;
            sbq.delete();
        end else begin
            pass = (ph == 0 || ph == 4);
            chk("ready", 32'(dbg_ready), 32'(ph == 0));
            chk("stall", 32'(cpu_stall), 32'(ph >= 1 && ph <= 3));
            if (pass) begin
                chk("pass_dst", 32'(mem_dst), 32'(cd));
                chk("pass_x", 32'(mem_x), 32'(cx));
                chk("a_reg", 32'(a_reg), 32'(m_a));
                chk("d_reg", 32'(d_reg), 32'(m_d));
                old_a = m_a;
                if (cd.a_star) m_ram[old_a] = cx;
                if (cd.a)      m_a = cx;
                if (cd.d)      m_d = cx;
            end else begin
                chk("no_d_store", 32'(mem_dst.d), 32'd0);
            end
            if (ph == 0) begin
                if (reqq.size() > 0) begin
                    req_t q;
                    exp_t e;
                    q = reqq.pop_front();
                    t_we = q.we; t_addr = q.addr; t_wdata = q.wdata;
                    e.cyc = cyc + 3;
                    e.is_read = !q.we;
                    e.rdata = m_ram[q.addr];
                    sbq.push_back(e);
                    ph = 1;
                end
            end else if (ph == 4) begin
                ph = 0;
            end else begin
                if (ph == 2 && t_we) m_ram[t_addr] = t_wdata;
                ph = ph + 1;
            end
        end
    endtask

    function automatic req_t mk_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
        req_t q;
        q.we = we; q.addr = addr; q.wdata = wdata;
        return q;
    endfunction

    dst_flag_t NONE_D = '0;
    dst_flag_t A_D    = '{a: 1'b1, d: 1'b0, a_star: 1'b0};
    dst_flag_t D_D    = '{a: 1'b0, d: 1'b1, a_star: 1'b0};
    dst_flag_t AS_D   = '{a: 1'b0, d: 1'b0, a_star: 1'b1};
    dst_flag_t ALL_D  = '{a: 1'b1, d: 1'b1, a_star: 1'b1};

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram[i] = '0;
            m_ram[i] = '0;
        end
        a_reg = '0; d_reg = '0; m_a = '0; m_d = '0; ph = 0;
        t_we = 1'b0; t_addr = '0; t_wdata = '0;

        run_cycle(1'b0, NONE_D, 16'h0);
        run_cycle(1'b0, NONE_D, 16'h0);

        // Write with A=0x0010, D=0x00D0.
        run_cycle(1'b1, A_D, 16'h0010);
        run_cycle(1'b1, D_D, 16'h00D0);
        reqq.push_back(mk_req(1'b1, 16'h0200, 16'hBEEF));
        for (int i = 0; i < 6; i++) run_cycle(1'b1, NONE_D, 16'h0);
        chk("w_ram", 32'(ram[16'h0200]), 32'h0000BEEF);
        chk("w_a", 32'(a_reg), 32'h00000010);
        chk("w_d", 32'(d_reg), 32'h000000D0);

        // Read of preloaded RAM[0x0005]=0x1234 with A=0x0100.
        run_cycle(1'b1, A_D, 16'h0005);
        run_cycle(1'b1, AS_D, 16'h1234);
        run_cycle(1'b1, A_D, 16'h0100);
        reqq.push_back(mk_req(1'b0, 16'h0005, 16'h0));
        for (int i = 0; i < 8; i++) run_cycle(1'b1, NONE_D, 16'h0);
        chk("r_rdata", 32'(dbg_rdata), 32'h00001234);
        chk("r_a", 32'(a_reg), 32'h00000100);

        // CPU A-store in the accept cycle.
        reqq.push_back(mk_req(1'b0, 16'h0007, 16'h0));
        run_cycle(1'b1, A_D, 16'h0042);
        for (int i = 0; i < 5; i++) run_cycle(1'b1, NONE_D, 16'h0);
        chk("acc_a", 32'(a_reg), 32'h00000042);

        // Back-to-back writes with the CPU storing D every cycle.
        reqq.push_back(mk_req(1'b1, 16'h0011, 16'hAAAA));
        reqq.push_back(mk_req(1'b1, 16'h0012, 16'h5555));
        for (int i = 0; i < 12; i++) run_cycle(1'b1, D_D, 16'(16'h0300 + i));
        chk("b2b_ram0", 32'(ram[16'h0011]), 32'h0000AAAA);
        chk("b2b_ram1", 32'(ram[16'h0012]), 32'h00005555);

        // Reset in ACCESS of a write.
        reqq.push_back(mk_req(1'b1, 16'h0300, 16'h1111));
        run_cycle(1'b1, NONE_D, 16'h0);
        run_cycle(1'b1, NONE_D, 16'h0);
        run_cycle(1'b0, NONE_D, 16'h0);
        for (int i = 0; i < 3; i++) run_cycle(1'b1, NONE_D, 16'h0);
        chk("rst_no_write", 32'(ram[16'h0300]), 32'h0);
        chk("rst_rdata", 32'(dbg_rdata), 32'h0);

        // Stall isolation: CPU hammers every store with 0xFFFF.
        run_cycle(1'b1, A_D, 16'h0009);
        reqq.push_back(mk_req(1'b0, 16'h0009, 16'h0));
        for (int i = 0; i < 6; i++) run_cycle(1'b1, ALL_D, 16'hFFFF);

        // Randomized traffic on a small address window so collisions occur.
        for (int i = 0; i < 3000; i++) begin
            dst_flag_t cd;
            cd = dst_flag_t'($urandom_range(0, 7));
            if (reqq.size() == 0 && $urandom_range(0, 3) == 0)
                reqq.push_back(mk_req(1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)),
                                      16'($urandom)));
            if ($urandom_range(0, 299) == 0) begin
                run_cycle(1'b0, cd, 16'($urandom_range(0, 31)));
                reqq.delete();
            end else begin
                run_cycle(1'b1, cd, 16'($urandom_range(0, 31)));
            end
        end
        reqq.delete();
        for (int i = 0; i < 6; i++) run_cycle(1'b1, NONE_D, 16'h0);
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        for (int i = 0; i < 32; i++) chk("ram_final", 32'(ram[i]), 32'(m_ram[i]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
